// File: rtl/hv_pwm_sched_pkg.sv
// Shared types and timing defaults for the HV PWM return-channel scheduler.
// The LV-side decoder imports the same bit and gap timing.
package hv_pwm_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BIT  = 2'd1,
      GAP  = 2'd2
   } hv_pwm_sched_st_e;

   localparam int HV_PWM_BIT_CYC = 8;
   localparam int HV_PWM_GAP_CYC = 4;

endpackage

// File: rtl/hv_rr_arb.sv
// Combinational round-robin arbiter: rotate the request vector so that the
// pointer sits at bit 0, pick the lowest set bit, then rotate the grant back.
module hv_rr_arb #(
   parameter int REQ_NUM = 3,
   parameter int PTR_W   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
   input  logic [REQ_NUM-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [REQ_NUM-1:0] o_gnt
);

   logic [2*REQ_NUM-1:0] req_dbl;
   logic [2*REQ_NUM-1:0] gnt_dbl;
   logic [REQ_NUM-1:0]   req_rot;
   logic [REQ_NUM-1:0]   gnt_rot;

   // Rotate, find first, rotate back
   always_comb begin
      req_dbl = {i_req, i_req} >> i_ptr;
      req_rot = req_dbl[REQ_NUM-1:0];
      gnt_rot = '0;
      for (int i = REQ_NUM - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            gnt_rot    = '0;
            gnt_rot[i] = 1'b1;
         end
      end
      gnt_dbl = {gnt_rot, gnt_rot} << i_ptr;
      o_gnt   = gnt_dbl[2*REQ_NUM-1:REQ_NUM];
   end

endmodule

// File: rtl/hv_pwm_msg_sched.sv
// Round-robin frame scheduler and bit serializer for the HV PWM return
// channel. Outside a frame the gate wave is passed through (registered).
module hv_pwm_msg_sched
   import hv_pwm_sched_pkg::*;
#(
   parameter int REQ_NUM   = 3,
   parameter int FRM_BIT_W = 4,
   parameter int LEN_W     = $clog2(FRM_BIT_W + 1),
   parameter int BIT_CYC   = HV_PWM_BIT_CYC,
   parameter int GAP_CYC   = HV_PWM_GAP_CYC
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_en,
   input  logic [REQ_NUM-1:0]           i_req,
   input  logic [REQ_NUM*FRM_BIT_W-1:0] i_req_data,
   input  logic [REQ_NUM*LEN_W-1:0]     i_req_len,
   output logic [REQ_NUM-1:0]           o_ack,
   input  logic                         i_pwm_gwave,
   output logic                         o_pwm_out,
   output logic                         o_busy
);

   localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
   localparam int CYC_W = $clog2((BIT_CYC > GAP_CYC) ? BIT_CYC : GAP_CYC);

   hv_pwm_sched_st_e st_q, st_nxt;
   logic [PTR_W-1:0]     ptr_q, ptr_nxt;
   logic [CYC_W-1:0]     cyc_q, cyc_nxt;
   logic [LEN_W-1:0]     bit_q, bit_nxt;
   logic [LEN_W-1:0]     len_q, len_nxt;
   logic [FRM_BIT_W-1:0] data_q, data_nxt, data_sh;
   logic                 lock_q, lock_nxt;
   logic [REQ_NUM-1:0]   ack_nxt, gnt;
   logic                 out_nxt, grant_ok;
   logic [PTR_W-1:0]     w_idx;
   logic [FRM_BIT_W-1:0] sel_data;
   logic [LEN_W-1:0]     raw_len, sel_len;

   hv_rr_arb #(.REQ_NUM(REQ_NUM), .PTR_W(PTR_W)) u_arb (
      .i_req (i_req),
      .i_ptr (ptr_q),
      .o_gnt (gnt)
   );

   assign grant_ok = (st_q == IDLE) && i_en && (|i_req);

   // Winner's index, payload and length; over-long frames are clamped
   always_comb begin
      w_idx    = '0;
      sel_data = '0;
      raw_len  = '0;
      for (int k = 0; k < REQ_NUM; k++) begin
         if (gnt[k]) begin
            w_idx    = PTR_W'(k);
            sel_data = i_req_data[k*FRM_BIT_W +: FRM_BIT_W];
            raw_len  = i_req_len[k*LEN_W +: LEN_W];
         end
      end
      sel_len = (raw_len > LEN_W'(FRM_BIT_W)) ? LEN_W'(FRM_BIT_W) : raw_len;
   end

   // Next-state, counters, latches and next output level
   always_comb begin
      st_nxt   = st_q;
      ptr_nxt  = ptr_q;
      cyc_nxt  = cyc_q;
      bit_nxt  = bit_q;
      len_nxt  = len_q;
      data_nxt = data_q;
      lock_nxt = lock_q;
      ack_nxt  = '0;
      case (st_q)
         IDLE: begin
            if (grant_ok) begin
               data_nxt = sel_data;
               len_nxt  = sel_len;
               lock_nxt = i_pwm_gwave;
               bit_nxt  = '0;
               cyc_nxt  = '0;
               ack_nxt  = gnt;
               ptr_nxt  = (w_idx == PTR_W'(REQ_NUM - 1)) ? '0 : w_idx + PTR_W'(1);
               st_nxt   = (sel_len == '0) ? GAP : BIT;
            end
         end
         BIT: begin
            if (cyc_q == CYC_W'(BIT_CYC - 1)) begin
               cyc_nxt = '0;
               if (bit_q == len_q - LEN_W'(1)) st_nxt  = GAP;
               else                            bit_nxt = bit_q + LEN_W'(1);
            end else begin
               cyc_nxt = cyc_q + CYC_W'(1);
            end
         end
         GAP: begin
            if (cyc_q == CYC_W'(GAP_CYC - 1)) begin
               cyc_nxt = '0;
               st_nxt  = IDLE;
            end else begin
               cyc_nxt = cyc_q + CYC_W'(1);
            end
         end
         default: st_nxt = IDLE;
      endcase
      // A '1' bit inverts the locked gate level, a '0' bit repeats it
      data_sh = data_nxt >> bit_nxt;
      out_nxt = (st_nxt == BIT) ? (data_sh[0] ^ lock_nxt) : i_pwm_gwave;
   end

   // State and datapath registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         st_q      <= IDLE;
         ptr_q     <= '0;
         cyc_q     <= '0;
         bit_q     <= '0;
         len_q     <= '0;
         data_q    <= '0;
         lock_q    <= 1'b0;
         o_ack     <= '0;
         o_pwm_out <= 1'b0;
      end else begin
         st_q      <= st_nxt;
         ptr_q     <= ptr_nxt;
         cyc_q     <= cyc_nxt;
         bit_q     <= bit_nxt;
         len_q     <= len_nxt;
         data_q    <= data_nxt;
         lock_q    <= lock_nxt;
         o_ack     <= ack_nxt;
         o_pwm_out <= out_nxt;
      end
   end

   assign o_busy = (st_q != IDLE);

   // Requesters must never ask for more bits than a frame holds
   a_len_legal: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      grant_ok |-> (raw_len <= LEN_W'(FRM_BIT_W)));

endmodule

// File: doc/hv_pwm_msg_sched.md
# hv_pwm_msg_sched

Scheduler and serializer for the HV-side PWM return channel, which is reused to carry status frames back to the LV side. It round-robin arbitrates up to `REQ_NUM` frame requesters (INTB state, fault code, watchdog heartbeat, …) and serializes the granted frame onto the channel. Outside a frame it passes the PWM gate wave through unchanged. It sits between the HV status sources and the PWM return pad driver.

## Interface
**Parameters**
- `REQ_NUM`, 3: number of requesters.
- `FRM_BIT_W`, 4: maximum frame length in bits.
- `LEN_W`, `$clog2(FRM_BIT_W+1)`: width of each length field.
- `BIT_CYC`, 8: clock cycles per transmitted bit; must be ≥ 2.
- `GAP_CYC`, 4: minimum idle cycles after a frame; must be ≥ 1.

**Ports**
- `i_clk`, input, 1: the single clock.
- `i_rst_n`, input, 1: asynchronous, active-low reset.
- `i_en`, input, 1: scheduler enable. While low, no new grant is issued; a frame already in flight completes.
- `i_req`, input, `REQ_NUM`: per-requester frame pending. Held high until acked.
- `i_req_data`, input, `REQ_NUM*FRM_BIT_W`: frame payload. Requester k uses slice k; transmitted LSB first.
- `i_req_len`, input, `REQ_NUM*LEN_W`: frame length in bits per requester. Valid range 0..`FRM_BIT_W`.
- `o_ack`, output, `REQ_NUM`: one-hot, one-cycle pulse; payload accepted.
- `i_pwm_gwave`, input, 1: PWM gate wave.
- `o_pwm_out`, output, 1: channel output.
- `o_busy`, output, 1: high whenever state ≠ IDLE.

## Operation
- **FSM states:** IDLE, BIT, GAP. Encoding is the `hv_pwm_sched_st_e` enum.
- **IDLE**
  - If `i_en & |i_req`, the arbiter picks winner w.
  - Latch `data_w`, `len_w` and `i_pwm_gwave` (into `gwave_lock`).
  - Clear `bit_idx` and `cyc_cnt`.
  - If `len_w == 0`, go to GAP; otherwise go to BIT.
  - In all other cases, stay in IDLE.
- **Arbitration:** round-robin.
  - The pointer `rr_ptr` resets to 0.
  - The winner is the first requester at index ≥ `rr_ptr` (wrapping) with `i_req` set.
  - After each grant, `rr_ptr <= (w+1) mod REQ_NUM`.
  - Requests are sampled only in IDLE. A request withdrawn before its grant is simply dropped.
- **BIT**
  - `cyc_cnt` counts 0..`BIT_CYC-1`.
  - On `cyc_cnt == BIT_CYC-1`:
    - If `bit_idx == len-1`, go to GAP.
    - Otherwise increment `bit_idx` and clear `cyc_cnt`.
- **GAP**
  - `cyc_cnt` counts 0..`GAP_CYC-1`, then the FSM goes to IDLE.
  - The gap is inserted after every frame, including zero-length frames.
- **Bit encoding:** the level for bit b is `b ? ~gwave_lock : gwave_lock`, constant for `BIT_CYC` cycles.
- **Output:** `o_pwm_out` is registered.
  - Next value is the bit level when the next state is BIT.
  - Otherwise the next value is `i_pwm_gwave` (pass-through in IDLE and GAP).
- **Requester contract:** `i_req_len > FRM_BIT_W` is illegal. The RTL clamps it to `FRM_BIT_W`, and an assertion flags it.
- **Enable:** deasserting `i_en` in BIT or GAP has no effect until IDLE is reached.
- **Counter widths:** `cyc_cnt` is `$clog2(max(BIT_CYC,GAP_CYC))` bits. `bit_idx` is `LEN_W` bits. No wrap is reachable beyond the terminal counts.

## Timing
- **Reset values:**
  - `o_pwm_out` = 0, `o_ack` = 0, `o_busy` = 0.
  - state = IDLE, `rr_ptr` = 0.
  - All latches and counters = 0.
- **Ack latency:** request seen in IDLE at edge N → `o_ack[w]` high during cycle N+1 only. Also at N+1: state = BIT or GAP and `o_busy` = 1.
- **Output latency:** the first bit level appears on `o_pwm_out` at cycle N+1, because the output is registered from the next state.
- **Frame length:** the frame occupies `len*BIT_CYC` cycles on `o_pwm_out`, followed by `GAP_CYC` cycles of pass-through.
- **Back-to-back:** the earliest next grant is at the edge after the last GAP cycle. Min frame-to-frame spacing is `len*BIT_CYC + GAP_CYC + 1` cycles.
- **Simultaneous requests:** exactly one ack per grant. Losers keep `i_req` high and win in later rounds, in rotation.
- **Async reset mid-frame:** the frame is aborted immediately and `o_pwm_out` goes to 0. After reset release, pass-through resumes from the next edge.

## Structure
- **`hv_pwm_sched_pkg`** holds:
  - the `hv_pwm_sched_st_e` state enum;
  - default values for `BIT_CYC` and `GAP_CYC`, shared with the LV-side decoder.
- **Sub-module `hv_rr_arb`**, parameterised by `REQ_NUM`:
  - inputs: request vector, pointer;
  - output: one-hot grant.
  - It is combinational. The pointer register stays in the scheduler.

## Test plan
- **Single frame, high gwave:** `REQ_NUM=3`, req0 with len=3, data=3'b101, `i_pwm_gwave=1`. Expect ack0 one cycle later, then `o_pwm_out` = 0,1,0 for 8 cycles each, then 4 gap cycles following gwave.
- **Three simultaneous requests:** req0, req1 and req2 all high and held. Expect grants in order 0,1,2. Then re-raise all three with `rr_ptr=0`: order 0,1,2 again. With only req0 and req2 raised after granting 1, the grant goes to 2 first.
- **Zero-length frame:** len=0. Expect an ack, no bit cycles, 4 gap cycles, and `o_busy` high for exactly 4 cycles.
- **Enable drop mid-frame:** `i_en` falls during BIT. The frame completes. With `i_en` held low, a pending req1 gets no ack until `i_en` returns.
- **Reset mid-frame:** assert `i_rst_n` low during bit 2. Expect `o_pwm_out` = 0, `o_busy` = 0 and `o_ack` = 0 immediately. After release, `o_pwm_out` tracks gwave until the next request.
- **Gwave lock:** toggle `i_pwm_gwave` during a frame. The bit levels must not change within the frame (`gwave_lock` holds); the gap cycles follow the live gwave.
